ets_stream_packer: RTL and testbench

ETS_STREAM_PACKER -- requirements
Module: ets_stream_packer

---
 rtl/ets_pkg.sv | 25 ++
 rtl/ets_stream_packer_if.sv | 22 ++
 rtl/ets_word_fifo.sv | 66 ++++++
 rtl/ets_stream_packer.sv | 206 ++++++++++++++++++++
 tb/tb_ets_stream_packer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ets_pkg.sv
// Shared types and constants for the ETS stream packer.
//   state_e  : capture FSM states
//   WORD_W   : output word width
//   DEF_*    : default parameter values
//   idx_w()  : index width for an N-entry space, never less than 1 bit
package ets_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_PHASES    = 10;
  localparam int unsigned DEF_PAT_W     = 32;
  localparam int unsigned DEF_REC_WORDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_NEXT    = 2'd3
  } state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ets_stream_packer_if.sv
// AXI-Stream bus carrying packed record words.
//   tvalid/tready : handshake
//   tdata         : 32-bit record word
//   tlast         : final word of a record
//   tuser         : comparator channel the record came from
interface ets_stream_packer_if
  import ets_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH
);
  localparam int unsigned USER_W = idx_w(NUM_CH);

  logic              tvalid;
  logic              tready;
  logic [WORD_W-1:0] tdata;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);

endinterface

// File: rtl/ets_word_fifo.sv
// Two-entry output FIFO. Head entry is always ent0, so rd_data comes straight
// from a register and holds while the consumer stalls.
//   push/push_data : write side; a push into a full FIFO is dropped (drop_c)
//                    unless a pop happens in the same cycle
//   pop_ready      : consumer ready; pops when rd_valid
//   rd_valid/rd_data : registered head entry
//   valid_d_c      : next-cycle value of rd_valid
module ets_word_fifo #(
  parameter int unsigned W = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         valid_d_c,
  output logic         drop_c
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic         valid_q;
  logic         pop_c;
  logic         accept_c;

  // Pop first, then place an accepted push behind whatever remains.
  always_comb begin
    cnt_d    = cnt_q;
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    pop_c    = pop_ready && (cnt_q != 2'd0);
    accept_c = push && ((cnt_q != 2'd2) || pop_c);
    drop_c   = push && !accept_c;
    if (pop_c) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (accept_c) begin
      if (cnt_d == 2'd0) ent0_d = push_data;
      else               ent1_d = push_data;
      cnt_d = cnt_d + 2'd1;
    end
    valid_d_c = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      valid_q <= valid_d_c;
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = ent0_q;

endmodule

// File: rtl/ets_stream_packer.sv
// Equivalent-time sampling packer: drives a phase-pattern table to the
// transceiver, captures one comparator channel per record aligned to phase 0,
// packs samples LSB-first into 32-bit words and streams them out over AXIS.
//   sample_clk, rst          : clock, synchronous active-high reset
//   cmp_data                 : raw comparator bits
//   pat_wr_*                 : pattern table write port
//   start/mode/ch_sel        : capture request (mode 1 = all channels in turn)
//   pat_data/phase_idx       : current pattern word / phase
//   busy/overflow            : activity and sticky drop flag
//   m_axis                   : record word stream, tuser = channel
module ets_stream_packer
  import ets_pkg::*;
#(
  parameter  int unsigned NUM_CH    = DEF_NUM_CH,
  parameter  int unsigned PHASES    = DEF_PHASES,
  parameter  int unsigned PAT_W     = DEF_PAT_W,
  parameter  int unsigned REC_WORDS = DEF_REC_WORDS,
  localparam int unsigned CH_W      = idx_w(NUM_CH),
  localparam int unsigned PH_W      = idx_w(PHASES)
) (
  input  logic                sample_clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   cmp_data,
  input  logic                pat_wr_en,
  input  logic [PH_W-1:0]     pat_wr_addr,
  input  logic [PAT_W-1:0]    pat_wr_data,
  input  logic                start,
  input  logic                mode,
  input  logic [CH_W-1:0]     ch_sel,
  output logic [PAT_W-1:0]    pat_data,
  output logic [PH_W-1:0]     phase_idx,
  output logic                busy,
  output logic                overflow,
  ets_stream_packer_if.master m_axis
);

  localparam int unsigned WC_W   = idx_w(REC_WORDS);
  localparam int unsigned BIT_W  = idx_w(WORD_W);
  localparam int unsigned FIFO_W = WORD_W + 1 + CH_W;

  logic [PAT_W-1:0]  table_q [PHASES];
  logic [PAT_W-1:0]  pat_data_q;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              pat_we_c;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              start_ok_c;

  // Sample-issue markers, delayed one cycle to line up with sample_q.
  logic              sv_q, sv_d;
  logic              sw_q, sw_d;
  logic              sl_q, sl_d;

  logic [NUM_CH-1:0] cmp_q;
  logic              sample_q;
  logic [WORD_W-2:0] sh_q, sh_d;
  logic [WORD_W-1:0] word_c;
  logic              push_c;
  logic [FIFO_W-1:0] push_payload_c;

  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;

  logic              fifo_valid;
  logic [FIFO_W-1:0] fifo_head;
  logic              fifo_valid_d_c;
  logic              drop_c;

  // Phase counter and table write qualification.
  always_comb begin
    phase_d  = (phase_q == PH_W'(PHASES - 1)) ? '0 : phase_q + PH_W'(1);
    pat_we_c = pat_wr_en && (32'(pat_wr_addr) < PHASES);
  end

  // Pattern table; the read uses the pre-write contents (old data on collision).
  always_ff @(posedge sample_clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PHASES); i++) table_q[i] <= '0;
      pat_data_q <= '0;
      phase_q    <= '0;
    end else begin
      pat_data_q <= table_q[phase_q];
      phase_q    <= phase_d;
      if (pat_we_c) table_q[pat_wr_addr] <= pat_wr_data;
    end
  end

  // Capture FSM. In ARM at phase 0 the next CAPTURE cycle issues sample 0,
  // which reaches the packer as the comparator value seen at phase 0.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    ch_d       = ch_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    sv_d       = 1'b0;
    sw_d       = 1'b0;
    sl_d       = 1'b0;
    start_ok_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_ok_c = 1'b1;
          mode_d     = mode;
          ch_d       = mode ? '0 : ch_sel;
          state_d    = ST_ARM;
        end
      end
      ST_ARM: begin
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        if (phase_q == '0) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        sv_d      = 1'b1;
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
          sw_d       = 1'b1;
          word_cnt_d = word_cnt_q + WC_W'(1);
          if (word_cnt_q == WC_W'(REC_WORDS - 1)) begin
            sl_d    = 1'b1;
            state_d = (mode_q && (ch_q != CH_W'(NUM_CH - 1))) ? ST_NEXT : ST_IDLE;
          end
        end
      end
      ST_NEXT: begin
        ch_d    = ch_q + CH_W'(1);
        state_d = ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Packer: new sample enters at the top, so sample 0 ends at bit 0.
  always_comb begin
    sh_d           = sv_q ? {sample_q, sh_q[WORD_W-2:1]} : sh_q;
    word_c         = {sample_q, sh_q};
    push_c         = sv_q && sw_q;
    push_payload_c = {ch_q, sl_q, word_c};
    overflow_d     = overflow_q;
    if (start_ok_c)  overflow_d = 1'b0;
    else if (drop_c) overflow_d = 1'b1;
    busy_d = (state_d != ST_IDLE) || sv_d || fifo_valid_d_c;
  end

  always_ff @(posedge sample_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      ch_q       <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      sv_q       <= 1'b0;
      sw_q       <= 1'b0;
      sl_q       <= 1'b0;
      cmp_q      <= '0;
      sample_q   <= 1'b0;
      sh_q       <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      ch_q       <= ch_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sv_q       <= sv_d;
      sw_q       <= sw_d;
      sl_q       <= sl_d;
      cmp_q      <= cmp_data;
      sample_q   <= cmp_q[ch_q];
      sh_q       <= sh_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  ets_word_fifo #(
    .W (FIFO_W)
  ) u_fifo (
    .clk       (sample_clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (push_payload_c),
    .pop_ready (m_axis.tready),
    .rd_valid  (fifo_valid),
    .rd_data   (fifo_head),
    .valid_d_c (fifo_valid_d_c),
    .drop_c    (drop_c)
  );

  assign m_axis.tvalid = fifo_valid;
  assign m_axis.tdata  = fifo_head[WORD_W-1:0];
  assign m_axis.tlast  = fifo_head[WORD_W];
  assign m_axis.tuser  = fifo_head[WORD_W+1 +: CH_W];

  assign pat_data  = pat_data_q;
  assign phase_idx = phase_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ets_stream_packer.sv
// Directed bench for ets_stream_packer (NUM_CH=4, PHASES=10, REC_WORDS=4).
module tb_ets_stream_packer;

  logic        clk;
  logic        rst;
  logic [3:0]  cmp_data;
  logic        pat_wr_en;
  logic [3:0]  pat_wr_addr;
  logic [31:0] pat_wr_data;
  logic        start;
  logic        mode;
  logic [1:0]  ch_sel;
  logic [31:0] pat_data;
  logic [3:0]  phase_idx;
  logic        busy;
  logic        overflow;

  ets_stream_packer_if #(.NUM_CH(4)) axis ();

  ets_stream_packer #(
    .NUM_CH    (4),
    .PHASES    (10),
    .PAT_W     (32),
    .REC_WORDS (4)
  ) dut (
    .sample_clk  (clk),
    .rst         (rst),
    .cmp_data    (cmp_data),
    .pat_wr_en   (pat_wr_en),
    .pat_wr_addr (pat_wr_addr),
    .pat_wr_data (pat_wr_data),
    .start       (start),
    .mode        (mode),
    .ch_sel      (ch_sel),
    .pat_data    (pat_data),
    .phase_idx   (phase_idx),
    .busy        (busy),
    .overflow    (overflow),
    .m_axis      (axis)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q_data [$];
  bit          q_last [$];
  logic [1:0]  q_user [$];

  // Comparator stimulus: 0 constant, 1 bit2 high on even phases,
  // 2 bit2 high only at phase 0, 3 all bits high only at phase 0.
  int          gen_mode = 0;
  logic [3:0]  cmp_const = 4'h0;

  // Words produced by a single pulse at phase 0 of every 10-phase period.
  logic [31:0] align_w [4] = '{32'h40100401, 32'h10040100, 32'h04010040, 32'h01004010};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (gen_mode)
        1:       cmp_data = {1'b0, (phase_idx[0] == 1'b0), 2'b00};
        2:       cmp_data = {1'b0, (phase_idx == 4'd0), 2'b00};
        3:       cmp_data = {4{(phase_idx == 4'd0)}};
        default: cmp_data = cmp_const;
      endcase
    end
  end

  // Beat monitor: handshake seen at negedge transfers on the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (axis.tvalid && axis.tready) begin
        q_data.push_back(axis.tdata);
        q_last.push_back(axis.tlast);
        q_user.push_back(axis.tuser);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_user.delete();
  endtask

  task automatic do_start(input logic m, input logic [1:0] ch);
    start  = 1'b1;
    mode   = m;
    ch_sel = ch;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (q_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    n_cmp += 8;
    if (phase_idx !== 4'd0) begin $display("FAIL rst_phase: got %0d want 0", phase_idx); n_bad++; end
    if (pat_data !== 32'h0) begin $display("FAIL rst_pat: got %h want 0", pat_data); n_bad++; end
    if (axis.tvalid !== 1'b0) begin $display("FAIL rst_tvalid: got %b want 0", axis.tvalid); n_bad++; end
    if (axis.tdata !== 32'h0) begin $display("FAIL rst_tdata: got %h want 0", axis.tdata); n_bad++; end
    if (axis.tlast !== 1'b0) begin $display("FAIL rst_tlast: got %b want 0", axis.tlast); n_bad++; end
    if (axis.tuser !== 2'd0) begin $display("FAIL rst_tuser: got %0d want 0", axis.tuser); n_bad++; end
    if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); n_bad++; end
    if (overflow !== 1'b0) begin $display("FAIL rst_overflow: got %b want 0", overflow); n_bad++; end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_pattern();
    int k;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pat_wr_en   = 1'b1;
      pat_wr_addr = 4'(i);
      pat_wr_data = 32'hA0 + 32'(i);
      tick(1);
    end
    pat_wr_addr = 4'd12;
    pat_wr_data = 32'hDEAD;
    tick(1);
    pat_wr_addr = 4'd15;
    tick(1);
    pat_wr_en = 1'b0;
    k = 12;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      n_cmp += 2;
      if (phase_idx !== 4'(k % 10)) begin
        $display("FAIL pat_phase[%0d]: got %0d want %0d", k, phase_idx, k % 10); n_bad++;
      end
      if (pat_data !== 32'hA0 + 32'((k - 1) % 10)) begin
        $display("FAIL pat_data[%0d]: got %h want %h", k, pat_data, 32'hA0 + 32'((k - 1) % 10)); n_bad++;
      end
      tick(1);
      k++;
    end
  endtask

  task automatic test_single();
    bit ok;
    gen_mode = 1;
    axis.tready = 1'b1;
    clear_q();
    do_start(1'b0, 2'd2);
    ch_sel = 2'd0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin $display("FAIL single_busy: got %b want 1", busy); n_bad++; end
    wait_beats(4, 300, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL single_timeout: got %0d beats want 4", q_data.size()); n_bad++; end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (j >= q_data.size()) begin
        $display("FAIL single_beat[%0d]: got none want beat", j); n_bad++;
      end else if (q_data[j] !== 32'h55555555 || q_last[j] !== (j == 3) || q_user[j] !== 2'd2) begin
        $display("FAIL single_beat[%0d]: got %h/%b/%0d want 55555555/%b/2", j, q_data[j], q_last[j], q_user[j], j == 3);
        n_bad++;
      end
    end
    tick(3);
    @(negedge clk);
    n_cmp += 2;
    if (busy !== 1'b0) begin $display("FAIL single_idle_busy: got %b want 0", busy); n_bad++; end
    if (q_data.size() !== 4) begin $display("FAIL single_count: got %0d want 4", q_data.size()); n_bad++; end
  endtask

  task automatic test_align();
    bit ok;
    gen_mode = 2;
    clear_q();
    do_start(1'b0, 2'd2);
    wait_beats(4, 300, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL align_timeout: got %0d beats want 4", q_data.size()); n_bad++; end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (j >= q_data.size()) begin
        $display("FAIL align_beat[%0d]: got none want %h", j, align_w[j]); n_bad++;
      end else if (q_data[j] !== align_w[j] || q_last[j] !== (j == 3)) begin
        $display("FAIL align_beat[%0d]: got %h/%b want %h/%b", j, q_data[j], q_last[j], align_w[j], j == 3);
        n_bad++;
      end
    end
    tick(3);
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [31:0] exp_d;
    gen_mode  = 0;
    cmp_const = 4'b1010;
    clear_q();
    do_start(1'b1, 2'd3);
    wait_beats(16, 800, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL rr_timeout: got %0d beats want 16", q_data.size()); n_bad++; end
    for (int j = 0; j < 16; j++) begin
      exp_d = ((j / 4) % 2 == 1) ? 32'hFFFFFFFF : 32'h0;
      n_cmp++;
      if (j >= q_data.size()) begin
        $display("FAIL rr_beat[%0d]: got none want beat", j); n_bad++;
      end else if (q_data[j] !== exp_d || q_last[j] !== (j % 4 == 3) || q_user[j] !== 2'(j / 4)) begin
        $display("FAIL rr_beat[%0d]: got %h/%b/%0d want %h/%b/%0d", j, q_data[j], q_last[j], q_user[j],
                 exp_d, j % 4 == 3, j / 4);
        n_bad++;
      end
    end
    tick(5);
    @(negedge clk);
    n_cmp++;
    if (q_data.size() !== 16) begin $display("FAIL rr_count: got %0d want 16", q_data.size()); n_bad++; end
  endtask

  task automatic test_realign();
    bit ok;
    gen_mode = 3;
    clear_q();
    do_start(1'b1, 2'd0);
    wait_beats(16, 800, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL realign_timeout: got %0d beats want 16", q_data.size()); n_bad++; end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (j >= q_data.size()) begin
        $display("FAIL realign_beat[%0d]: got none want %h", j, align_w[j % 4]); n_bad++;
      end else if (q_data[j] !== align_w[j % 4] || q_user[j] !== 2'(j / 4)) begin
        $display("FAIL realign_beat[%0d]: got %h/%0d want %h/%0d", j, q_data[j], q_user[j], align_w[j % 4], j / 4);
        n_bad++;
      end
    end
    tick(5);
  endtask

  task automatic test_overflow();
    bit ok;
    gen_mode = 2;
    axis.tready = 1'b0;
    clear_q();
    do_start(1'b0, 2'd2);
    tick(200);
    @(negedge clk);
    n_cmp += 3;
    if (overflow !== 1'b1) begin $display("FAIL ovf_flag: got %b want 1", overflow); n_bad++; end
    if (axis.tvalid !== 1'b1) begin $display("FAIL ovf_tvalid: got %b want 1", axis.tvalid); n_bad++; end
    if (axis.tdata !== align_w[0]) begin $display("FAIL ovf_head: got %h want %h", axis.tdata, align_w[0]); n_bad++; end
    tick(1);
    axis.tready = 1'b1;
    wait_beats(2, 10, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL ovf_timeout: got %0d beats want 2", q_data.size()); n_bad++; end
    for (int j = 0; j < 2; j++) begin
      n_cmp++;
      if (j >= q_data.size()) begin
        $display("FAIL ovf_beat[%0d]: got none want %h", j, align_w[j]); n_bad++;
      end else if (q_data[j] !== align_w[j] || q_last[j] !== 1'b0) begin
        $display("FAIL ovf_beat[%0d]: got %h/%b want %h/0", j, q_data[j], q_last[j], align_w[j]); n_bad++;
      end
    end
    tick(4);
    @(negedge clk);
    n_cmp += 4;
    if (q_data.size() !== 2) begin $display("FAIL ovf_count: got %0d want 2", q_data.size()); n_bad++; end
    if (axis.tvalid !== 1'b0) begin $display("FAIL ovf_drained: got %b want 0", axis.tvalid); n_bad++; end
    if (overflow !== 1'b1) begin $display("FAIL ovf_sticky: got %b want 1", overflow); n_bad++; end
    if (busy !== 1'b0) begin $display("FAIL ovf_busy: got %b want 0", busy); n_bad++; end
    tick(1);
    do_start(1'b0, 2'd2);
    @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b0) begin $display("FAIL ovf_clear: got %b want 0", overflow); n_bad++; end
    wait_beats(6, 300, ok);
    tick(3);
  endtask

  task automatic test_collide();
    bit ok;
    logic [3:0] p;
    gen_mode = 1;
    clear_q();
    do_start(1'b0, 2'd2);
    tick(20);
    p           = phase_idx;
    start       = 1'b1;
    pat_wr_en   = 1'b1;
    pat_wr_addr = p;
    pat_wr_data = 32'hBEEF0000 | 32'(p);
    tick(1);
    start     = 1'b0;
    pat_wr_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pat_data !== 32'hA0 + 32'(p)) begin
      $display("FAIL coll_old: got %h want %h", pat_data, 32'hA0 + 32'(p)); n_bad++;
    end
    tick(10);
    @(negedge clk);
    n_cmp++;
    if (pat_data !== (32'hBEEF0000 | 32'(p))) begin
      $display("FAIL coll_new: got %h want %h", pat_data, 32'hBEEF0000 | 32'(p)); n_bad++;
    end
    wait_beats(4, 300, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL coll_timeout: got %0d beats want 4", q_data.size()); n_bad++; end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (j >= q_data.size()) begin
        $display("FAIL coll_beat[%0d]: got none want beat", j); n_bad++;
      end else if (q_data[j] !== 32'h55555555 || q_last[j] !== (j == 3)) begin
        $display("FAIL coll_beat[%0d]: got %h/%b want 55555555/%b", j, q_data[j], q_last[j], j == 3); n_bad++;
      end
    end
    tick(200);
    @(negedge clk);
    n_cmp += 2;
    if (q_data.size() !== 4) begin $display("FAIL coll_count: got %0d want 4", q_data.size()); n_bad++; end
    if (busy !== 1'b0) begin $display("FAIL coll_busy: got %b want 0", busy); n_bad++; end
  endtask

  task automatic test_rst_mid();
    bit ok;
    gen_mode = 1;
    clear_q();
    do_start(1'b0, 2'd2);
    wait_beats(1, 300, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL rmid_timeout: got %0d beats want 1", q_data.size()); n_bad++; end
    tick(8);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    n_cmp += 7;
    if (axis.tvalid !== 1'b0) begin $display("FAIL rmid_tvalid: got %b want 0", axis.tvalid); n_bad++; end
    if (axis.tdata !== 32'h0) begin $display("FAIL rmid_tdata: got %h want 0", axis.tdata); n_bad++; end
    if (axis.tlast !== 1'b0) begin $display("FAIL rmid_tlast: got %b want 0", axis.tlast); n_bad++; end
    if (busy !== 1'b0) begin $display("FAIL rmid_busy: got %b want 0", busy); n_bad++; end
    if (overflow !== 1'b0) begin $display("FAIL rmid_ovf: got %b want 0", overflow); n_bad++; end
    if (phase_idx !== 4'd0) begin $display("FAIL rmid_phase: got %0d want 0", phase_idx); n_bad++; end
    if (pat_data !== 32'h0) begin $display("FAIL rmid_pat: got %h want 0", pat_data); n_bad++; end
    rst = 1'b0;
    tick(300);
    n_cmp++;
    if (q_data.size() !== 1) begin $display("FAIL rmid_no_beat: got %0d beats want 1", q_data.size()); n_bad++; end
    clear_q();
    do_start(1'b0, 2'd2);
    wait_beats(4, 300, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL rmid_new_timeout: got %0d beats want 4", q_data.size()); n_bad++; end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (j >= q_data.size()) begin
        $display("FAIL rmid_beat[%0d]: got none want beat", j); n_bad++;
      end else if (q_data[j] !== 32'h55555555 || q_last[j] !== (j == 3) || q_user[j] !== 2'd2) begin
        $display("FAIL rmid_beat[%0d]: got %h/%b/%0d want 55555555/%b/2", j, q_data[j], q_last[j], q_user[j], j == 3);
        n_bad++;
      end
    end
    tick(5);
  endtask

  initial begin
    rst         = 1'b1;
    cmp_data    = 4'h0;
    pat_wr_en   = 1'b0;
    pat_wr_addr = 4'd0;
    pat_wr_data = 32'h0;
    start       = 1'b0;
    mode        = 1'b0;
    ch_sel      = 2'd0;
    axis.tready = 1'b1;
    test_reset();
    test_pattern();
    test_single();
    test_align();
    test_round_robin();
    test_realign();
    test_overflow();
    test_collide();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
